// File: rtl/fc_tx_tlp_arbiter.sv
// Round-robin TX TLP scheduler over the MWr/MRd/Cpl queues: requests flow-control credit,
// pops the granted head, starts the datapath and holds the link until the TLP is done.
module fc_tx_tlp_arbiter #(
   parameter int unsigned WAIT_MAX = 16,
   parameter bit          CPL_PRIO = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  q_valid_i,
   input  logic [23:0] q_size_i,
   output logic [2:0]  q_pop_o,
   output logic        fc_req_o,
   output logic [1:0]  fc_type_o,
   output logic [7:0]  fc_size_o,
   input  logic        fc_grant_i,
   output logic        tx_start_o,
   output logic [1:0]  tx_sel_o,
   input  logic        tx_done_i,
   output logic        busy_o
);

   localparam int unsigned CNT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam int unsigned SIZE_W  = 8;
   localparam int unsigned SEL_W   = 2;
   localparam logic [1:0]  Q_MWR   = 2'd0;
   localparam logic [1:0]  Q_MRD   = 2'd1;
   localparam logic [1:0]  Q_CPL   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XMIT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [SIZE_W-1:0]  r_size;
   logic [SIZE_W-1:0]  w_size_nxt;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]   w_wait_nxt;
   logic [SEL_W-1:0]   r_rr_ptr;
   logic [SEL_W-1:0]   w_rr_nxt;

   logic               w_any_valid;
   logic [SEL_W-1:0]   w_pick;
   logic [SIZE_W-1:0]  w_pick_size;
   logic               w_sel_valid;

   logic [2:0]         w_pop_nxt;
   logic               w_start_nxt;
   logic               w_req_nxt;
   logic [1:0]         w_type_nxt;
   logic [SIZE_W-1:0]  w_fc_size_nxt;
   logic [1:0]         w_tx_sel_nxt;
   logic               w_busy_nxt;

   // First valid queue after ptr, searching ptr+1, ptr+2, ptr (mod 3).
   function automatic logic [SEL_W-1:0] rr_pick(input logic [2:0] v, input logic [SEL_W-1:0] ptr);
      int unsigned idx;
      rr_pick = Q_MWR;
      for (int k = 3; k >= 1; k--) begin
         idx = 32'(ptr) + 32'(k);
         if (idx >= 3) idx = idx - 3;
         if (v[idx[1:0]]) rr_pick = idx[1:0];
      end
   endfunction

   // Arbitration winner and its head size.
   always_comb begin
      w_any_valid = |q_valid_i;
      if (CPL_PRIO && q_valid_i[2]) w_pick = Q_CPL;
      else                          w_pick = rr_pick(q_valid_i, r_rr_ptr);
      case (w_pick)
         Q_MWR:   w_pick_size = q_size_i[7:0];
         Q_MRD:   w_pick_size = q_size_i[15:8];
         default: w_pick_size = q_size_i[23:16];
      endcase
      case (r_sel)
         Q_MWR:   w_sel_valid = q_valid_i[0];
         Q_MRD:   w_sel_valid = q_valid_i[1];
         Q_CPL:   w_sel_valid = q_valid_i[2];
         default: w_sel_valid = 1'b0;
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_size_nxt  = r_size;
      w_wait_nxt  = r_wait_cnt;
      w_rr_nxt    = r_rr_ptr;
      w_pop_nxt   = 3'b000;
      w_start_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_any_valid) begin
               w_sel_nxt   = w_pick;
               w_size_nxt  = w_pick_size;
               w_wait_nxt  = '0;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (!w_sel_valid) begin
               // Head vanished under us: abandon without popping, keep rr position.
               w_wait_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else if (fc_grant_i) begin
               w_pop_nxt   = 3'(3'b001 << r_sel);
               w_start_nxt = 1'b1;
               w_wait_nxt  = '0;
               w_state_nxt = S_XMIT;
            end else if (r_wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
               w_rr_nxt    = r_sel;
               w_wait_nxt  = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_wait_nxt  = CNT_W'(r_wait_cnt + 1'b1);
            end
         end
         S_XMIT: begin
            if (tx_done_i) begin
               w_rr_nxt    = r_sel;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_req_nxt     = (w_state_nxt == S_REQ);
      w_type_nxt    = w_req_nxt ? w_sel_nxt : 2'd0;
      w_fc_size_nxt = w_req_nxt ? w_size_nxt : '0;
      w_tx_sel_nxt  = (w_state_nxt == S_XMIT) ? w_sel_nxt : 2'd0;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
   end

   // State, context and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sel      <= Q_MWR;
         r_size     <= '0;
         r_wait_cnt <= '0;
         r_rr_ptr   <= Q_CPL;
         q_pop_o    <= 3'b000;
         fc_req_o   <= 1'b0;
         fc_type_o  <= 2'd0;
         fc_size_o  <= '0;
         tx_start_o <= 1'b0;
         tx_sel_o   <= 2'd0;
         busy_o     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_size     <= w_size_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_rr_ptr   <= w_rr_nxt;
         q_pop_o    <= w_pop_nxt;
         fc_req_o   <= w_req_nxt;
         fc_type_o  <= w_type_nxt;
         fc_size_o  <= w_fc_size_nxt;
         tx_start_o <= w_start_nxt;
         tx_sel_o   <= w_tx_sel_nxt;
         busy_o     <= w_busy_nxt;
      end
   end

endmodule
